// File: rtl/case_8_prod_acc.sv
// Product accumulator: sums N_TERMS signed products from a multiplier stream
// and holds each finished sum behind a valid/ready output handshake.
module case_8_prod_acc #(
    parameter int DIN_WIDTH = 11,
    parameter int ACC_WIDTH = 16,
    parameter int N_TERMS   = 8
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic signed [DIN_WIDTH-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        clear,
    output logic signed [ACC_WIDTH-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int               CNT_W    = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_next_state;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic        [CNT_W-1:0]     r_cnt;
    logic signed [ACC_WIDTH-1:0] r_out_data;
    logic                        r_out_valid;
    logic signed [ACC_WIDTH-1:0] w_sext;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic                        w_in_hs;
    logic                        w_out_hs;
    logic                        w_last;

    // Sign extension comes from the signed port; the sum wraps at ACC_WIDTH.
    assign w_sext   = ACC_WIDTH'(in_data);
    assign w_sum    = r_acc + w_sext;
    assign w_in_hs  = in_valid & in_ready;
    assign w_out_hs = r_out_valid & out_ready;
    assign w_last   = (r_cnt == LAST_CNT);

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && !clear && w_last) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (w_out_hs) begin
                    w_next_state = ACCUM;
                end
            end
            default: w_next_state = ACCUM;
        endcase
    end

    // Clear beats a coincident beat; in HOLD nothing but out_ready matters.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ACCUM && clear) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_in_hs) begin
                if (w_last) begin
                    r_out_data  <= w_sum;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/case_8_prod_acc.md
CASE_8_PROD_ACC -- requirements
Module: case_8_prod_acc

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 11, meaning signed product width consumed from the upstream multiplier.
REQ-002 SHALL have parameter ACC_WIDTH, default 16, meaning signed accumulator and result width; legal range ACC_WIDTH >= DIN_WIDTH.
REQ-003 SHALL have parameter N_TERMS, default 8, meaning products summed per result; legal range N_TERMS >= 2.
REQ-004 SHALL have port ap_clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port ap_rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port in_data, input, DIN_WIDTH, a signed product.
REQ-007 SHALL have port in_valid, input, 1, in_data valid.
REQ-008 SHALL have port in_ready, output, 1, block accepts in_data.
REQ-009 SHALL have port clear, input, 1, synchronous flush of partial accumulation.
REQ-010 SHALL have port out_data, output, ACC_WIDTH, the signed sum.
REQ-011 SHALL have port out_valid, output, 1, out_data valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts out_data.

Function
REQ-013 SHALL implement two states, ACCUM and HOLD; input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
REQ-014 SHALL drive in_ready = 1 in ACCUM and 0 in HOLD, combinationally from state only; in_ready SHALL NOT depend on in_valid.
REQ-015 SHALL, on each ACCUM input handshake, sign-extend in_data to ACC_WIDTH, add it to acc, and increment term counter cnt (width clog2(N_TERMS)).
REQ-016 SHALL, on the input handshake with cnt == N_TERMS-1, register out_data = acc + sext(in_data), set out_valid = 1, clear acc and cnt to 0, and enter HOLD; out_valid SHALL rise the cycle after the Nth handshake (latency 1).
REQ-017 SHALL perform all additions modulo 2^ACC_WIDTH (two's-complement wrap, no saturation, no overflow flag).
REQ-018 SHALL hold out_data and out_valid stable in HOLD until an output handshake.
REQ-019 SHALL, on an output handshake, deassert out_valid the next cycle and return to ACCUM; the next input SHALL NOT be accepted in the handshake cycle itself.
REQ-020 SHALL, when clear = 1 in ACCUM, set acc and cnt to 0 next cycle; a simultaneous input handshake SHALL be consumed and discarded (clear wins).
REQ-021 SHALL ignore clear in HOLD; the pending result is neither altered nor dropped.
REQ-022 SHALL leave out_data at its last value after the output handshake; out_data is meaningful only while out_valid = 1.
REQ-023 SHALL treat in_valid in HOLD as a no-op; no state change.

Reset
REQ-024 SHALL, on a clock edge with ap_rst_n = 0, set state = ACCUM, acc = 0, cnt = 0, out_valid = 0, and out_data = 0; in_ready = 1 from the first cycle after reset.
REQ-025 SHALL let reset override every other input, including mid-accumulation and in HOLD; a pending result is lost.
REQ-026 SHALL perform no asynchronous action; ap_rst_n changes SHALL take effect only at a clock edge.

Verification
REQ-027 Defaults, out_ready = 1, 8 back-to-back beats of -1024 -> out_valid one cycle after beat 8, out_data = 0xE000 (-8192), in_ready = 0 for exactly one cycle.
REQ-028 Defaults, beats 1..8 (values 1..8) with in_valid toggling every other cycle -> out_data = 36; cnt advances only on handshakes.
REQ-029 ACC_WIDTH = 12, 8 beats of 1023 -> out_data = 0xFF8 (-8), wrap with no flag.
REQ-030 Defaults, out_ready = 0 for 5 cycles after result -> out_valid and out_data held; in_valid = 1 is ignored, in_ready = 0; after out_ready = 1, the next sum starts from 0.
REQ-031 Defaults, 3 beats of 100, then clear coincident with a beat of 50, then 8 beats of 2 -> out_data = 16; clear in HOLD leaves the pending value intact.
REQ-032 Defaults, ap_rst_n = 0 for one cycle after 5 beats -> acc/cnt cleared, out_valid = 0; the next 8 beats of 3 give out_data = 24.
